// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, addresses the combinational instruction ROM, and latches
// the fetched word with its PC+4 for decode. Arbitrates every next-PC
// source (redirect, eret, interrupt vector, stall hold, sequential fetch)
// and implements the syscall halt/resume state machine.
//
// Optional feature macro: FETCH_IRQ_EN
//   defined   -> interrupt acceptance, in-service flag, epc_out and the
//                int_trigger_out/int_num_out pulse are built in.
//   undefined -> int_req/int_num are ignored and the interrupt outputs
//                are tied to zero; eret still returns to epc_in.

module fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_BASE = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        eret,
    input  logic [31:0] epc_in,
    input  logic        int_req,
    input  logic [1:0]  int_num,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] PC_plus_out,
    output logic        nop_out,
    output logic        int_trigger_out,
    output logic [1:0]  int_num_out,
    output logic [31:0] epc_out
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] irq_vector;
    logic        running;
    logic        irq_accept;
    logic        halt_take;
    logic        load_bubble;
    logic        hold_ifid;

    assign running   = (state == RUN);
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // A halt from EX is ignored when EX is also redirecting: the redirect
    // belongs to an older instruction and squashes the syscall path.
    assign halt_take = running && halt && !redirect;

`ifdef FETCH_IRQ_EN
    logic in_service;

    assign irq_vector = IRQ_BASE + {28'd0, int_num, 2'b00};
    assign irq_accept = int_req && !in_service && running && !redirect && !eret;

    // In-service flag: set on interrupt entry, cleared by a selected eret.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_service <= 1'b0;
        end else if (running && !redirect && eret) begin
            in_service <= 1'b0;
        end else if (irq_accept) begin
            in_service <= 1'b1;
        end
    end

    // Interrupt entry outputs: one-cycle trigger pulse with its source and
    // the PC of the instruction that was not fetched, kept for CP0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_trigger_out <= 1'b0;
            int_num_out     <= 2'b00;
            epc_out         <= 32'd0;
        end else begin
            int_trigger_out <= irq_accept;
            int_num_out     <= irq_accept ? int_num : 2'b00;
            if (irq_accept) begin
                epc_out <= pc;
            end
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{int_req, int_num};
    assign irq_vector        = IRQ_BASE;
    assign irq_accept        = 1'b0;
    assign int_trigger_out   = 1'b0;
    assign int_num_out       = 2'b00;
    assign epc_out           = 32'd0;
`endif

    // Next-PC selection; the PC stays frozen whenever the machine is halted.
    always_comb begin
        next_pc = pc;
        if (running) begin
            if (redirect) begin
                next_pc = redirect_pc;
            end else if (eret) begin
                next_pc = epc_in;
            end else if (irq_accept) begin
                next_pc = irq_vector;
            end else if (halt_take || stall) begin
                next_pc = pc;
            end else begin
                next_pc = pc_plus4;
            end
        end
    end

    // Bubble whenever the word at the current PC must not reach decode:
    // control transfers, interrupt entry, the halt-entry cycle and HALT.
    // The halt-entry PC is re-fetched after resume, so it is squashed here.
    assign load_bubble = !running || redirect || eret || irq_accept || halt_take;
    assign hold_ifid   = stall && !load_bubble;

    // RUN/HALT control state machine.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (halt_take) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID pipeline register: bubble, hold on load-use stall, or capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_out   <= 32'd0;
            PC_plus_out <= 32'd0;
            nop_out     <= 1'b1;
        end else if (load_bubble) begin
            instr_out   <= 32'd0;
            PC_plus_out <= 32'd0;
            nop_out     <= 1'b1;
        end else if (!hold_ifid) begin
            instr_out   <= imem_rdata;
            PC_plus_out <= pc_plus4;
            nop_out     <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register of the five-stage CPU. Holds the program counter, drives the instruction-memory address, and latches the fetched word plus its PC+4 into the decode stage. Decode feeds the ID/EX register from these outputs. The block arbitrates every next-PC source: sequential fetch, branch/jump redirect from EX, `eret` return, and interrupt vectoring. It also inserts bubbles and implements the syscall halt/resume state machine.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IRQ_BASE`, default 32'h0000_0800: base of the interrupt vector table.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  1  load-use hold from the hazard unit.
- `redirect`  in  1  taken branch/jump resolved in EX.
- `redirect_pc`  in  32  target for `redirect`.
- `eret`  in  1  exception return resolved in EX.
- `epc_in`  in  32  return address for `eret`, from CP0.
- `int_req`  in  1  level interrupt request.
- `int_num`  in  2  interrupt source index.
- `halt`  in  1  syscall-halt pulse from EX.
- `resume`  in  1  resume-from-halt pulse (board button, pre-debounced).
- `imem_addr`  out  32  current PC; instruction ROM is combinational.
- `imem_rdata`  in  32  instruction at `imem_addr`, valid the same cycle.
- `instr_out`  out  32  latched instruction to decode.
- `PC_plus_out`  out  32  latched PC+4 of `instr_out`.
- `nop_out`  out  1  1 = IF/ID holds a bubble. Decode forwards this to ID/EX `nop`.
- `int_trigger_out`  out  1  one-cycle pulse: an interrupt was taken.
- `int_num_out`  out  2  source of the taken interrupt.
- `epc_out`  out  32  PC saved at interrupt entry, written to CP0.

## Operation
- State machine with two states: RUN and HALT.
  - RUN → HALT when `halt`=1 and `redirect`=0.
  - HALT → RUN when `resume`=1.
- Next-PC priority in RUN, highest first:
  1. `redirect` → `redirect_pc`.
  2. `eret` → `epc_in`; also clears the in-service flag.
  3. Interrupt accepted → `IRQ_BASE + {int_num,2'b00}`.
  4. `stall` → hold PC.
  5. Otherwise → PC+4.
- Interrupt is accepted when all of the following hold: `int_req`=1, in-service flag = 0, state RUN, `redirect`=0, `eret`=0.
- On interrupt acceptance:
  - set the in-service flag;
  - `epc_out` ← current PC (the unfetched instruction);
  - `int_trigger_out`=1 and `int_num_out`=`int_num` for the next cycle only.
- IF/ID update:
  - On redirect, `eret`, interrupt acceptance, or while in HALT: load a bubble (`instr_out`=0, `PC_plus_out`=0, `nop_out`=1).
  - On `stall` with none of the above: hold all IF/ID contents.
  - Otherwise: load `imem_rdata`, PC+4, `nop_out`=0.
- In HALT the PC is frozen. After `resume`, fetch restarts at the frozen PC.
- `redirect` and `stall` in the same cycle: redirect wins, because EX is older.
- PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (`rst`=0 at an edge) gives:
  - PC=`RESET_PC`, state RUN, in-service flag 0;
  - `instr_out`=0, `PC_plus_out`=0, `nop_out`=1;
  - `int_trigger_out`=0, `int_num_out`=0, `epc_out`=0.
- Reset dominates every other input, including mid-HALT and in the same cycle as redirect or interrupt.
- Fetch latency is one cycle: the word addressed at edge N appears on `instr_out` after edge N+1.
- Redirect penalty is one bubble on IF/ID; the target word follows on the next edge.
- `halt` and `resume` in the same cycle: in RUN, `halt` is taken; in HALT, `resume` is taken.
- `int_req` held high after acceptance does not re-trigger until `eret` clears the flag. It can be accepted again the cycle after `eret`.

## Configuration
- `FETCH_IRQ_EN` defined: interrupt acceptance, in-service flag, `epc_out`, and the `int_trigger_out`/`int_num_out` logic are compiled in.
- `FETCH_IRQ_EN` undefined:
  - `int_req`/`int_num` are ignored;
  - `int_trigger_out`=0, `int_num_out`=0, `epc_out`=0 constantly;
  - `eret` still redirects to `epc_in`.

## Test plan
- Reset with `RESET_PC`=0, then release: `imem_addr` steps 0, 4, 8. `instr_out` tracks the ROM one cycle behind; `nop_out` goes 1 → 0 after the first fetch.
- `stall` for 2 cycles at PC=8: PC stays 8 and IF/ID holds the word from address 4 for both cycles, then fetch resumes at 12.
- `redirect`=1 with `redirect_pc`=32'h40 in the same cycle as `stall`=1: next PC=32'h40, one bubble (`nop_out`=1), then the word at 32'h40.
- `int_req`=1, `int_num`=2 at PC=32'h20:
  - next PC=32'h808, `epc_out`=32'h20;
  - `int_trigger_out` pulses for one cycle with `int_num_out`=2;
  - `int_req` still high → no re-entry;
  - `eret` with `epc_in`=32'h20 → PC=32'h20, then the interrupt re-enters.
- `halt` at PC=32'h30: IF/ID shows bubbles and the PC is frozen for 5 cycles. `resume` → fetch at 32'h30. Repeat with `rst`=0 mid-HALT → PC=`RESET_PC`, state RUN.
- Build without `FETCH_IRQ_EN`: `int_req`=1 has no effect and `int_trigger_out` stays 0.
